// File: rtl/clz_denorm_if.sv
// clz_denorm_if -- request/result handshake bundle for clz_denorm.
// The err member and its modport entries are present only when
// CLZ_DENORM_ERR_EN is defined.
interface clz_denorm_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] norm_val;
  logic [5:0]  lz_count;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_val;
`ifdef CLZ_DENORM_ERR_EN
  logic        err;
`endif

  // Producer/consumer side (drives requests, accepts results)
  modport master (
    output in_valid, norm_val, lz_count, out_ready,
    input  in_ready, out_valid, out_val
`ifdef CLZ_DENORM_ERR_EN
    , input err
`endif
  );

  // Denormalizer side
  modport slave (
    input  in_valid, norm_val, lz_count, out_ready,
    output in_ready, out_valid, out_val
`ifdef CLZ_DENORM_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/clz_denorm.sv
// clz_denorm -- iterative denormalizer: out_val = norm_val >> min(lz_count, 32).
// Shifts SHIFT_STEP bits per cycle (1, 2, 4, 8 or 16), then a final partial
// shift by the remainder. One request in flight; in_ready only in IDLE.
// Optional feature macro: CLZ_DENORM_ERR_EN (adds err for lz_count > 32).
module clz_denorm #(
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic         clk,
  input  logic         reset,
  clz_denorm_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [5:0] STEP_REM = 6'(SHIFT_STEP);
  localparam logic [5:0] MAX_CNT  = 6'd32;

  state_e      state_q, state_d;
  logic [31:0] data_q,  data_d;
  logic [5:0]  rem_q,   rem_d;
  logic [5:0]  cnt_clamped;
  logic        cnt_over;
`ifdef CLZ_DENORM_ERR_EN
  logic        err_q,   err_d;
`endif

  // Clamp the requested count to the 0..32 range the datapath handles
  always_comb begin
    cnt_over    = (bus.lz_count > MAX_CNT);
    cnt_clamped = cnt_over ? MAX_CNT : bus.lz_count;
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
`ifdef CLZ_DENORM_ERR_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.norm_val;
          rem_d   = cnt_clamped;
`ifdef CLZ_DENORM_ERR_EN
          err_d   = cnt_over;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (rem_q >= STEP_REM) begin
          data_d = data_q >> SHIFT_STEP;
          rem_d  = rem_q - STEP_REM;
        end else begin
          // Remainder is below one step: finish with a partial shift,
          // which is a no-op when the remainder is already zero.
          data_d  = data_q >> rem_q;
          rem_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
`ifdef CLZ_DENORM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
`ifdef CLZ_DENORM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Handshake outputs decode straight from the state register
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.out_val   = data_q;
`ifdef CLZ_DENORM_ERR_EN
    bus.err       = err_q && (state_q == DONE);
`endif
  end

endmodule

// File: tb/tb_clz_denorm.sv
// tb_clz_denorm -- self-checking bench for clz_denorm (SHIFT_STEP 4 and 1).
// Honours CLZ_DENORM_ERR_EN when defined.
module tb_clz_denorm;

  logic        clk;
  logic        rst  [2];
  logic        iv   [2];
  logic [31:0] nv   [2];
  logic [5:0]  lz   [2];
  logic        ordy [2];
  logic        ir   [2];
  logic        ov   [2];
  logic [31:0] ovl  [2];
`ifdef CLZ_DENORM_ERR_EN
  logic        er   [2];
`endif

  int n_checks = 0;
  int n_errors = 0;

  clz_denorm_if if0 ();
  clz_denorm_if if1 ();

  assign if0.in_valid  = iv[0];
  assign if0.norm_val  = nv[0];
  assign if0.lz_count  = lz[0];
  assign if0.out_ready = ordy[0];
  assign ir[0]  = if0.in_ready;
  assign ov[0]  = if0.out_valid;
  assign ovl[0] = if0.out_val;
  assign if1.in_valid  = iv[1];
  assign if1.norm_val  = nv[1];
  assign if1.lz_count  = lz[1];
  assign if1.out_ready = ordy[1];
  assign ir[1]  = if1.in_ready;
  assign ov[1]  = if1.out_valid;
  assign ovl[1] = if1.out_val;
`ifdef CLZ_DENORM_ERR_EN
  assign er[0] = if0.err;
  assign er[1] = if1.err;
`endif

  clz_denorm #(.SHIFT_STEP(4)) u_dut4 (.clk(clk), .reset(rst[0]), .bus(if0));
  clz_denorm #(.SHIFT_STEP(1)) u_dut1 (.clk(clk), .reset(rst[1]), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per DUT: busy flag, edges since accept, edges until result shows,
  // expected value and error flag.
  bit          m_busy [2];
  int          m_n    [2];
  int          m_lat  [2];
  logic [31:0] m_val  [2];
  bit          m_err  [2];
  int          step   [2];

  initial begin
    step[0] = 4;
    step[1] = 1;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0;
      m_n[d]    = 0;
      m_lat[d]  = 0;
      m_val[d]  = '0;
      m_err[d]  = 0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        m_busy[d] = 0;
      end else if (!m_busy[d]) begin
        if (iv[d]) begin
          int c;
          c = (lz[d] > 6'd32) ? 32 : int'(lz[d]);
          m_busy[d] = 1;
          m_n[d]    = 0;
          m_lat[d]  = c / step[d] + 1;
          m_val[d]  = (c >= 32) ? 32'h0 : (nv[d] >> c);
          m_err[d]  = (lz[d] > 6'd32);
        end
      end else if (m_n[d] >= m_lat[d]) begin
        if (ordy[d]) m_busy[d] = 0;
      end else begin
        m_n[d]++;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      bit vexp;
      vexp = m_busy[d] && (m_n[d] >= m_lat[d]);
      chk("m_in_ready", d, 32'(ir[d]), 32'(!m_busy[d]));
      chk("m_out_valid", d, 32'(ov[d]), 32'(vexp));
      if (rst[d]) chk("m_rst_out_val", d, ovl[d], 32'h0);
      if (vexp) begin
        chk("m_out_val", d, ovl[d], m_val[d]);
`ifdef CLZ_DENORM_ERR_EN
        chk("m_err", d, 32'(er[d]), 32'(m_err[d]));
`endif
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Called between edges; issues one request with out_ready held high and
  // checks result, first out_valid edge (accept edge = edge 0) and return to IDLE.
  task automatic run_req(input int d, input logic [31:0] v, input logic [5:0] c,
                         input logic [31:0] exp, input int exp_edge, input bit exp_err,
                         input string nm);
    int  cnt;
    bit  seen;
    chk({nm, "_in_ready"}, d, 32'(ir[d]), 32'h1);
    iv[d] = 1'b1; nv[d] = v; lz[d] = c; ordy[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    cnt = 0; seen = 0;
    while (!seen && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (ov[d]) seen = 1;
    end
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL %s_timeout dut%0d: no out_valid after %0d edges", nm, d, cnt);
    end else begin
      chk({nm, "_edge"}, d, 32'(cnt + 1), 32'(exp_edge));
      chk({nm, "_val"}, d, ovl[d], exp);
`ifdef CLZ_DENORM_ERR_EN
      chk({nm, "_err"}, d, 32'(er[d]), 32'(exp_err));
`else
      if (exp_err) ; // err port absent in this build
`endif
    end
    @(posedge clk); #1;
    chk({nm, "_post_valid"}, d, 32'(ov[d]), 32'h0);
    chk({nm, "_post_ready"}, d, 32'(ir[d]), 32'h1);
  endtask

  task automatic rand_drive(input int d, input int cycles);
    int sp [5];
    sp = '{0, 31, 32, 33, 63};
    repeat (cycles) begin
      @(posedge clk); #1;
      iv[d]   = ($urandom_range(0, 1) == 1);
      nv[d]   = $urandom;
      lz[d]   = ($urandom_range(0, 3) == 0) ? 6'(sp[$urandom_range(0, 4)])
                                            : 6'($urandom_range(0, 63));
      ordy[d] = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    iv[d] = 1'b0; ordy[d] = 1'b1;
    repeat (40) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    bit seen;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; iv[d] = 1'b0; nv[d] = '0; lz[d] = '0; ordy[d] = 1'b1;
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", d, 32'(ir[d]), 32'h1);
      chk("rst_out_valid", d, 32'(ov[d]), 32'h0);
      chk("rst_out_val", d, ovl[d], 32'h0);
`ifdef CLZ_DENORM_ERR_EN
      chk("rst_err", d, 32'(er[d]), 32'h0);
`endif
    end
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // First request lands on the first edge after reset release
    run_req(0, 32'hABC00000, 6'd20, 32'h00000ABC, 7,  0, "abc_lz20");
    run_req(0, 32'hFFFFFFFF, 6'd0,  32'hFFFFFFFF, 2,  0, "ones_lz0");
    run_req(0, 32'h80000000, 6'd31, 32'h00000001, 9,  0, "msb_lz31");
    run_req(0, 32'h12345678, 6'd32, 32'h00000000, 10, 0, "lz32");
    run_req(0, 32'hFFFFFFFF, 6'd45, 32'h00000000, 10, 1, "lz45");
    run_req(0, 32'h0000F000, 6'd4,  32'h00000F00, 3,  0, "unnorm_lz4");

    // Output stall: result and flags hold, in_valid ignored
    iv[0] = 1'b1; nv[0] = 32'h12345678; lz[0] = 6'd8; ordy[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    cnt = 0; seen = 0;
    while (!seen && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
      if (ov[0]) seen = 1;
    end
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL hold_timeout dut0: no out_valid after %0d edges", cnt);
    end
    repeat (5) begin
      iv[0] = 1'b1; nv[0] = 32'hDEADBEEF; lz[0] = 6'd0;
      @(posedge clk); #1;
      chk("hold_valid", 0, 32'(ov[0]), 32'h1);
      chk("hold_val", 0, ovl[0], 32'h00123456);
      chk("hold_in_ready", 0, 32'(ir[0]), 32'h0);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 0, 32'(ov[0]), 32'h0);
    chk("release_ready", 0, 32'(ir[0]), 32'h1);

    // Reset in the middle of a SHIFT sequence
    iv[0] = 1'b1; nv[0] = 32'hFFFFFFFF; lz[0] = 6'd28;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst[0] = 1'b1;
    #1;
    chk("abort_in_ready", 0, 32'(ir[0]), 32'h1);
    chk("abort_out_valid", 0, 32'(ov[0]), 32'h0);
    chk("abort_out_val", 0, ovl[0], 32'h0);
`ifdef CLZ_DENORM_ERR_EN
    chk("abort_err", 0, 32'(er[0]), 32'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      chk("abort_no_pulse", 0, 32'(ov[0]), 32'h0);
    end
    run_req(0, 32'h80000000, 6'd4, 32'h08000000, 3, 0, "after_abort");

    // Single-bit step
    run_req(1, 32'hC0000000, 6'd5,  32'h06000000, 7,  0, "s1_lz5");
    run_req(1, 32'hFFFFFFFF, 6'd32, 32'h00000000, 34, 0, "s1_lz32");
    run_req(1, 32'hA5A5A5A5, 6'd0,  32'hA5A5A5A5, 2,  0, "s1_lz0");

    // Randomized traffic on both instances, checked by the model
    fork
      rand_drive(0, 800);
      rand_drive(1, 800);
    join

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
